// File: rtl/barcode_frame_decoder_pkg.sv
// rtl/barcode_frame_decoder_pkg.sv - shared states, symbol constants and error codes for the barcode frame decoder
package bcr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        STOP  = 3'd2,
        CHECK = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [4:0] SYM_START = 5'b11100;
    localparam logic [4:0] SYM_STOP  = 5'b00111;

    localparam logic [1:0] ERR_SYM   = 2'd0;
    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;
    localparam logic [1:0] ERR_CHK   = 2'd3;

    // Input never exceeds 36, so three conditional subtracts always land in 0..9.
    function automatic logic [3:0] mod10_reduce(input logic [5:0] s);
        logic [5:0] r;
        r = s;
        for (int k = 0; k < 3; k++) begin
            if (r >= 6'd10) r = r - 6'd10;
        end
        return r[3:0];
    endfunction

endpackage

// File: rtl/barcode_frame_decoder_if.sv
// rtl/barcode_frame_decoder_if.sv - symbol input and digit output handshakes of the barcode frame decoder
interface barcode_frame_decoder_if;

    logic [4:0] sym;
    logic       sym_valid;
    logic       sym_ready;
    logic [3:0] out_digit;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output sym, sym_valid, out_ready,
        input  sym_ready, out_digit, out_valid, out_last
    );

    modport slave (
        input  sym, sym_valid, out_ready,
        output sym_ready, out_digit, out_valid, out_last
    );

endinterface

// File: rtl/barcode_frame_decoder_decode.sv
// rtl/barcode_frame_decoder_decode.sv - combinational two-of-five symbol classifier
module i2of5_decode
    import bcr_pkg::*;
(
    input  logic [4:0] sym,
    output logic       is_digit,
    output logic       is_start,
    output logic       is_stop,
    output logic [3:0] digit
);

    logic [2:0] ones;
    logic [3:0] wsum;

    always_comb begin
        ones = {2'b00, sym[4]} + {2'b00, sym[3]} + {2'b00, sym[2]}
             + {2'b00, sym[1]} + {2'b00, sym[0]};
        // Bit 0 is the parity bar and carries no weight.
        wsum = (sym[4] ? 4'd1 : 4'd0) + (sym[3] ? 4'd2 : 4'd0)
             + (sym[2] ? 4'd4 : 4'd0) + (sym[1] ? 4'd7 : 4'd0);
        is_start = (sym == SYM_START);
        is_stop  = (sym == SYM_STOP);
        is_digit = (ones == 3'd2);
        digit    = 4'd0;
        if (is_digit) digit = (wsum == 4'd11) ? 4'd0 : wsum;
    end

endmodule

// File: rtl/barcode_frame_decoder.sv
// rtl/barcode_frame_decoder.sv - frames, buffers and streams two-of-five barcode digits
// Define CHECKSUM_EN to treat the last symbol as a mod-10 check digit.
module barcode_frame_decoder
    import bcr_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    barcode_frame_decoder_if.slave  bus,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic [1:0]              err_code,
    output logic [2:0]              state
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
`ifdef CHECKSUM_EN
    localparam int EMIT_N = NUM_DIGITS - 1;
`else
    localparam int EMIT_N = NUM_DIGITS;
`endif
    localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(EMIT_N - 1);

    state_t           state_q, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [1:0]       err_q, err_n;
    logic [3:0]       dbuf [NUM_DIGITS];
    logic             wr_en;
    logic             clr_acc;
    logic             accept;
    logic             sym_ready_c;
    logic             out_valid_c;
    logic             out_last_c;
    logic [3:0]       out_digit_c;
    logic             done_c;
    logic             err_c;

    logic             dec_is_digit;
    logic             dec_is_start;
    logic             dec_is_stop;
    logic [3:0]       dec_digit;

    i2of5_decode u_decode (
        .sym      (bus.sym),
        .is_digit (dec_is_digit),
        .is_start (dec_is_start),
        .is_stop  (dec_is_stop),
        .digit    (dec_digit)
    );

    assign accept = bus.sym_valid && sym_ready_c;

`ifdef CHECKSUM_EN
    logic [3:0] acc_q;
    logic [5:0] acc_prod;
    logic [5:0] acc_sum;

    // Even positions weigh 3, odd positions weigh 1.
    assign acc_prod = idx_q[0] ? {2'b00, dec_digit}
                               : ({2'b00, dec_digit} + {1'b0, dec_digit, 1'b0});
    assign acc_sum  = {2'b00, acc_q} + acc_prod;

    always_ff @(posedge clock) begin
        if (reset || clr_acc) acc_q <= 4'd0;
        else if (wr_en)       acc_q <= mod10_reduce(acc_sum);
    end
`else
    logic unused_clr_acc;
    assign unused_clr_acc = clr_acc;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= ERR_SYM;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            err_q   <= err_n;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset) dbuf[idx_q] <= dec_digit;
    end

    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        err_n       = err_q;
        wr_en       = 1'b0;
        clr_acc     = 1'b0;
        sym_ready_c = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_digit_c = 4'd0;
        done_c      = 1'b0;
        err_c       = 1'b0;
        case (state_q)
            IDLE: begin
                sym_ready_c = 1'b1;
                if (bus.sym_valid && dec_is_start) begin
                    state_n = DATA;
                    idx_n   = '0;
                    clr_acc = 1'b1;
                end
            end
            DATA: begin
                sym_ready_c = 1'b1;
                if (bus.sym_valid) begin
                    if (dec_is_start) begin
                        idx_n   = '0;
                        clr_acc = 1'b1;
                    end else if (dec_is_digit) begin
                        wr_en = 1'b1;
                        idx_n = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IN) state_n = STOP;
                    end else if (dec_is_stop) begin
                        state_n = ERR;
                        err_n   = ERR_SHORT;
                    end else begin
                        state_n = ERR;
                        err_n   = ERR_SYM;
                    end
                end
            end
            STOP: begin
                sym_ready_c = 1'b1;
                if (bus.sym_valid) begin
                    if (dec_is_stop) begin
                        state_n = CHECK;
                    end else if (dec_is_digit || dec_is_start) begin
                        state_n = ERR;
                        err_n   = ERR_LONG;
                    end else begin
                        state_n = ERR;
                        err_n   = ERR_SYM;
                    end
                end
            end
            CHECK: begin
                idx_n   = '0;
                state_n = EMIT;
`ifdef CHECKSUM_EN
                if (acc_q != 4'd0) begin
                    state_n = ERR;
                    err_n   = ERR_CHK;
                end
`endif
            end
            EMIT: begin
                out_valid_c = 1'b1;
                out_digit_c = dbuf[idx_q];
                out_last_c  = (idx_q == LAST_OUT);
                if (bus.out_ready) begin
                    if (out_last_c) state_n = DONE;
                    else            idx_n   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            ERR: begin
                err_c   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // accept only gates the lint-visible handshake; the FSM already qualifies by state.
    logic unused_accept;
    assign unused_accept = accept;

    assign bus.sym_ready = sym_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_digit = out_digit_c;
    assign frame_done    = done_c;
    assign frame_err     = err_c;
    assign err_code      = err_q;
    assign state         = state_q;

endmodule

// File: tb/tb_barcode_frame_decoder.sv
// tb/tb_barcode_frame_decoder.sv - directed self-checking bench for barcode_frame_decoder
module tb_barcode_frame_decoder;
    import bcr_pkg::*;

    localparam int ND = 4;
`ifdef CHECKSUM_EN
    localparam int EN = 3;
`else
    localparam int EN = 4;
`endif

    localparam logic [4:0] D1  = 5'b10001;
    localparam logic [4:0] D2  = 5'b01001;
    localparam logic [4:0] D3  = 5'b11000;
    localparam logic [4:0] D4  = 5'b00101;
    localparam logic [4:0] D5  = 5'b10100;
    localparam logic [4:0] D6  = 5'b01100;
    localparam logic [4:0] BAD = 5'b11110;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic [2:0] state;
    int         n_assert = 0;
    int         n_fail   = 0;

    barcode_frame_decoder_if bus ();

    barcode_frame_decoder #(.NUM_DIGITS(ND)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .state      (state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [4:0] s);
        logic got;
        got = 1'b0;
        bus.sym       = s;
        bus.sym_valid = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clock);
            if (bus.sym_ready) got = 1'b1;
            @(posedge clock);
            #1;
        end
        bus.sym_valid = 1'b0;
        chk("sym_accept", 32'(got), 32'd1);
    endtask

    task automatic send_frame(input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c, input logic [4:0] d);
        send(SYM_START);
        send(a);
        send(b);
        send(c);
        send(d);
        send(SYM_STOP);
    endtask

    task automatic expect_emit(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        logic [3:0] e [4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        @(negedge clock);
        chk("check_state", 32'(state), 32'(CHECK));
        chk("check_no_valid", 32'(bus.out_valid), 32'd0);
        tick();
        for (int i = 0; i < EN; i++) begin
            @(negedge clock);
            chk("emit_valid", 32'(bus.out_valid), 32'd1);
            chk("emit_digit", 32'(bus.out_digit), 32'(e[i]));
            chk("emit_last", 32'(bus.out_last), 32'(i == EN - 1));
            tick();
        end
        @(negedge clock);
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_no_valid", 32'(bus.out_valid), 32'd0);
        tick();
        @(negedge clock);
        chk("done_clear", 32'(frame_done), 32'd0);
        chk("back_idle", 32'(state), 32'(IDLE));
        tick();
    endtask

    task automatic expect_err(input logic [1:0] code);
        @(negedge clock);
        chk("err_pulse", 32'(frame_err), 32'd1);
        chk("err_code", 32'(err_code), 32'(code));
        chk("err_no_valid", 32'(bus.out_valid), 32'd0);
        chk("err_state", 32'(state), 32'(ERR));
        tick();
        @(negedge clock);
        chk("err_clear", 32'(frame_err), 32'd0);
        chk("err_code_held", 32'(err_code), 32'(code));
        chk("err_idle", 32'(state), 32'(IDLE));
        tick();
    endtask

    initial begin
        int i;
        logic [3:0] ex [4];
        ex[0] = 4'd1; ex[1] = 4'd2; ex[2] = 4'd3; ex[3] = 4'd6;

        bus.sym       = SYM_START;
        bus.sym_valid = 1'b1;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_sym_ready", 32'(bus.sym_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_digit", 32'(bus.out_digit), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_state", 32'(state), 32'(IDLE));
        reset         = 1'b0;
        bus.sym_valid = 1'b0;
        tick();

`ifndef CHECKSUM_EN
        send_frame(D1, D2, D3, D4);
        expect_emit(4'd1, 4'd2, 4'd3, 4'd4);
`else
        send_frame(D1, D2, D3, D6);
        expect_emit(4'd1, 4'd2, 4'd3, 4'd6);
        send_frame(D1, D2, D3, D5);
        @(negedge clock);
        chk("chk_fail_check", 32'(state), 32'(CHECK));
        chk("chk_fail_novalid0", 32'(bus.out_valid), 32'd0);
        tick();
        expect_err(ERR_CHK);
`endif

        send(SYM_START); send(D1); send(D2); send(SYM_STOP);
        expect_err(ERR_SHORT);

        send(SYM_START); send(D1); send(BAD);
        expect_err(ERR_SYM);

        send(SYM_START); send(D1); send(D2); send(D3); send(D6); send(D1);
        expect_err(ERR_LONG);

        // A digit left over from the aborted frame would push this one into LONG.
        send(SYM_START); send(D5);
        send_frame(D1, D2, D3, D6);
        expect_emit(4'd1, 4'd2, 4'd3, 4'd6);

        send_frame(D1, D2, D3, D6);
        @(negedge clock);
        chk("stall_check", 32'(state), 32'(CHECK));
        tick();
        i = 0;
        for (int c = 0; c < 20 && i < EN; c++) begin
            bus.out_ready = c[0];
            @(negedge clock);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_digit", 32'(bus.out_digit), 32'(ex[i]));
            chk("stall_last", 32'(bus.out_last), 32'(i == EN - 1));
            chk("stall_sym_ready", 32'(bus.sym_ready), 32'd0);
            tick();
            if (bus.out_ready) i++;
        end
        chk("stall_count", 32'(i), 32'(EN));
        @(negedge clock);
        chk("stall_done", 32'(frame_done), 32'd1);
        chk("stall_done_ready", 32'(bus.sym_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("stall_idle", 32'(state), 32'(IDLE));
        tick();

        send_frame(D1, D2, D3, D6);
        tick();
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("mid_emit_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_emit_state", 32'(state), 32'(EMIT));
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk("rst_abort_state", 32'(state), 32'(IDLE));
        chk("rst_abort_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_abort_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("post_rst_err", 32'(frame_err), 32'd0);
        chk("post_rst_idle", 32'(state), 32'(IDLE));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/barcode_frame_decoder.md
# barcode_frame_decoder

Parametrised successor to the 5-bar barcode reader FSM. Accepts one 5-bit two-of-five bar pattern per handshake, frames it between START/STOP symbols, decodes a configurable number of digits into an internal buffer, optionally validates a mod-10 check digit, then streams the digits out over a valid/ready handshake. It sits between the bar-sampling front end and the display/host logic.

## Interface
- NUM_DIGITS, 8: symbols between START and STOP, check digit included when enabled; legal range 2..16.
- IDX_W, $clog2(NUM_DIGITS): localparam, buffer index width.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- sym  in  5  bar pattern; wide = 1; bit weights [4..0] = 1,2,4,7,P.
- sym_valid  in  1  sym is present.
- sym_ready  out  1  block accepts sym this cycle.
- out_digit  out  4  decoded digit 0..9.
- out_valid  out  1  out_digit is valid.
- out_ready  in  1  consumer takes out_digit.
- out_last  out  1  marks the final emitted digit.
- frame_done  out  1  one-cycle pulse: frame fully emitted.
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  2  0 SYM, 1 SHORT, 2 LONG, 3 CHK; held until the next frame_err.
- state  out  3  current FSM state, for debug.

## Operation
- Decode: exactly two 1s. Value = sum of weights; 4+7 = 0. Any other popcount, except START/STOP, is invalid.
- START = 5'b11100, STOP = 5'b00111.
- A symbol is accepted on sym_valid && sym_ready.
- sym_ready = 1 in IDLE, DATA and STOP; otherwise 0.
- IDLE: START resets idx and acc, then goes to DATA. Every other symbol is consumed and ignored.
- DATA:
  - A valid digit is written to buf[idx]; idx increments. When idx reaches NUM_DIGITS-1 on accept, go to STOP.
  - START mid-frame resyncs: idx = 0, acc = 0, stay in DATA.
  - STOP → ERR with SHORT. Invalid symbol → ERR with SYM.
- STOP state: STOP → CHECK. A digit or START → ERR with LONG. Invalid symbol → ERR with SYM.
- CHECK (one cycle): acc != 0 with checksum enabled → ERR with CHK. Otherwise → EMIT with idx = 0.
- EMIT:
  - out_valid = 1 and out_digit = buf[idx]. idx advances on out_ready.
  - out_last = 1 on the last emitted index. Handshake on the last digit → DONE.
- DONE: frame_done = 1 for one cycle, then IDLE.
- ERR: frame_err = 1 for one cycle, err_code updated, then IDLE. Buffer contents are discarded.
- Checksum accumulator:
  - acc is 4 bits, updated on each accepted digit: acc = (acc + w·d) mod 10.
  - w = 3 at even positions (0, 2, ...) and 1 at odd positions.
  - Reduce with at most three conditional subtracts of 10; the sum is ≤ 36.

## Timing
- Reset: state IDLE, idx = 0, acc = 0.
  - sym_ready = 1 (IDLE).
  - out_valid, out_last, frame_done, frame_err, out_digit and err_code all 0.
- Reset mid-frame aborts immediately. No frame_err is produced.
- STOP accepted at cycle N: CHECK at N+1; out_valid high (or frame_err) at N+2.
- out_valid stays high and out_digit stays stable until out_ready. No combinational path exists from out_ready to out_valid.
- Minimum back-to-back frame spacing is one IDLE cycle after DONE or ERR.

## Configuration
- CHECKSUM_EN defined:
  - The last buffered symbol is the check digit.
  - CHECK enforces acc == 0.
  - NUM_DIGITS-1 digits are emitted; the check digit is not emitted.
- CHECKSUM_EN undefined:
  - acc logic is removed.
  - CHECK always passes.
  - All NUM_DIGITS digits are emitted.
  - err_code 3 is never produced.

## Structure
- bcr_pkg holds:
  - the state enum: IDLE, DATA, STOP, CHECK, EMIT, DONE, ERR;
  - the START/STOP constants;
  - the err_code localparams.
- Sub-module i2of5_decode: combinational, sym → {is_digit, is_start, is_stop, digit[3:0]}. Instantiated once.

## Test plan
- Reset held 3 cycles with sym_valid = 1 → sym_ready = 1, all other outputs 0, state = IDLE.
- NUM_DIGITS = 4, no CHECKSUM_EN:
  - Input START, 10001, 01001, 11000, 00101, STOP with out_ready = 1.
  - Expect outputs 1, 2, 3, 4, out_last on 4, then frame_done 1 cycle later.
- NUM_DIGITS = 4, CHECKSUM_EN:
  - Digits 1, 2, 3, 6 → emits 1, 2, 3 then frame_done.
  - Digits 1, 2, 3, 5 → frame_err with err_code = 3 and no out_valid.
- STOP after two digits → frame_err, err_code = 1. Pattern 11110 in DATA → err_code = 0. A fifth digit where STOP is expected → err_code = 2.
- START, 1, START, then a full valid frame → only the second frame's digits are emitted.
- out_ready toggled 1/0 each cycle during EMIT → out_digit stable while stalled, sym_ready = 0 throughout. Reset asserted mid-EMIT → next cycle IDLE with out_valid = 0.
